ex_mem_stage: RTL and testbench

//  EX->MEM pipeline boundary of the SIMPLE pipeline. Selects the shifter result (SLL/SLR/SRL/SRA, op 8..11)
//  or the ALU result per instruction, registers it with destination/write-enable, and owns the

---
 rtl/ex_mem_stage.sv | 150 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline boundary.
//   Picks the shifter result (in_op[3:2]==2'b10, ops 8..11) or the ALU result,
//   registers it with rd/we behind a valid/ready handshake with a 2-entry
//   skid buffer (main register + skid entry), and owns the architectural
//   condition-code register {S,Z,C,V}.
// Ports:
//   clk, rst_n (sync, active low)
//   in_valid/in_ready, in_op, in_sh_data/in_sh_cond, in_alu_data/in_alu_cond,
//   in_rd, in_we, in_setcc   - EX side
//   flush                    - squash held and incoming entries
//   out_valid/out_ready, out_data, out_rd, out_we - MEM side
//   cc                       - condition codes {S,Z,C,V}
// Build option: define CC_BYPASS_EN to make cc show incoming flags in the
//   accepting cycle (combinational bypass); otherwise cc is the register.
module ex_mem_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_sh_data,
  input  logic [3:0]    in_sh_cond,
  input  logic [DW-1:0] in_alu_data,
  input  logic [3:0]    in_alu_cond,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic          in_setcc,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic [3:0]    cc
);

  // Occupancy: EMPTY (nothing held), MAIN (main only), FULL (main + skid).
  typedef enum logic [1:0] {OCC_EMPTY, OCC_MAIN, OCC_FULL} occ_e;

  occ_e          state_q, state_d;
  logic [DW-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [RW-1:0] main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic          main_we_q, main_we_d, skid_we_q, skid_we_d;
  logic [3:0]    cc_q, cc_d;

  logic          sel_sh, accept, xfer;
  logic [DW-1:0] sel_data;
  logic [3:0]    sel_cond;
  logic [1:0]    op_unused;

  assign op_unused = in_op[1:0];
  assign sel_sh    = (in_op[3:2] == 2'b10);
  assign sel_data  = sel_sh ? in_sh_data : in_alu_data;
  assign sel_cond  = sel_sh ? in_sh_cond : in_alu_cond;

  // in_ready is a decode of the state register, so it never depends on out_ready.
  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  assign out_data  = main_data_q;
  assign out_rd    = main_rd_q;
  assign out_we    = main_we_q & out_valid;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_we_d   = main_we_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_we_d   = skid_we_q;
    cc_d        = cc_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      if (accept && in_setcc) cc_d = sel_cond;
      unique case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_data_d = sel_data;
            main_rd_d   = in_rd;
            main_we_d   = in_we;
            state_d     = OCC_MAIN;
          end
        end
        OCC_MAIN: begin
          if (xfer) begin
            // Draining and refilling in the same cycle keeps full throughput.
            if (accept) begin
              main_data_d = sel_data;
              main_rd_d   = in_rd;
              main_we_d   = in_we;
            end else begin
              state_d = OCC_EMPTY;
            end
          end else if (accept) begin
            skid_data_d = sel_data;
            skid_rd_d   = in_rd;
            skid_we_d   = in_we;
            state_d     = OCC_FULL;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so no accept can race the skid entry.
          if (xfer) begin
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
            main_we_d   = skid_we_q;
            state_d     = OCC_MAIN;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_we_q   <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_we_q   <= 1'b0;
      cc_q        <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_we_q   <= main_we_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_we_q   <= skid_we_d;
      cc_q        <= cc_d;
    end
  end

`ifdef CC_BYPASS_EN
  assign cc = (rst_n && accept && in_setcc && !flush) ? sel_cond : cc_q;
`else
  assign cc = cc_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_we, in_setcc, flush;
  logic        out_valid, out_ready, out_we;
  logic [3:0]  in_op, in_sh_cond, in_alu_cond, cc;
  logic [15:0] in_sh_data, in_alu_data, out_data;
  logic [2:0]  in_rd, out_rd;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DW(16), .RW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_sh_data(in_sh_data), .in_sh_cond(in_sh_cond),
    .in_alu_data(in_alu_data), .in_alu_cond(in_alu_cond),
    .in_rd(in_rd), .in_we(in_we), .in_setcc(in_setcc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_we(out_we), .cc(cc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transfer to MEM is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got data=%0h rd=%0d expected none", out_data, out_rd);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e.data));
        chk("out_rd",   32'(out_rd),   32'(mon_e.rd));
        chk("out_we",   32'(out_we),   32'(mon_e.we));
      end
    end
  end

  task automatic drv(input logic [3:0] op, input logic [15:0] sh, input logic [15:0] alu,
                     input logic [2:0] rd, input logic we, input logic sc,
                     input logic [3:0] shc, input logic [3:0] aluc);
    in_valid = 1'b1; in_op = op; in_sh_data = sh; in_alu_data = alu;
    in_rd = rd; in_we = we; in_setcc = sc; in_sh_cond = shc; in_alu_cond = aluc;
  endtask

  // Holds the instruction until accepted; exp_data is the hand-computed result.
  task automatic issue(input logic [3:0] op, input logic [15:0] sh, input logic [15:0] alu,
                       input logic [2:0] rd, input logic we, input logic sc,
                       input logic [3:0] shc, input logic [3:0] aluc, input logic [15:0] exp_data);
    bit got = 0;
    drv(op, sh, alu, rd, we, sc, shc, aluc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{data: exp_data, rd: rd, we: we});
        got = 1;
      end
      @(posedge clk); #1;
      if (got) break;
    end
    if (!got) chk("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [3:0]  t_op[8]  = '{4'd7, 4'd8, 4'd11, 4'd12, 4'd3, 4'd10, 4'd15, 4'd9};
    logic [15:0] t_exp[8] = '{16'h5000, 16'hA001, 16'hA002, 16'h5003,
                              16'h5004, 16'hA005, 16'h5006, 16'hA007};
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drv(4'd0, 16'h1111, 16'h2222, 3'd1, 1'b1, 1'b1, 4'hF, 4'hF);

    // Reset held two cycles with in_valid high.
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready",  32'(in_ready),  32'(1));
      chk("rst_cc",        32'(cc),        32'(0));
      chk("rst_out_we",    32'(out_we),    32'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Source select.
    issue(4'd9, 16'h8001, 16'h1234, 3'd1, 1'b1, 1'b1, 4'b1000, 4'b0000, 16'h8001);
    chk("cc_after_shift", 32'(cc), 32'(4'b1000));
    issue(4'd0, 16'h8001, 16'h1234, 3'd2, 1'b1, 1'b0, 4'b1000, 4'b0101, 16'h1234);
    chk("cc_hold_nosetcc", 32'(cc), 32'(4'b1000));
    idle(3);

    // Backpressure: two accepted, third stalls until MEM drains.
    out_ready = 1'b0;
    issue(4'd0, 16'h0, 16'h0011, 3'd1, 1'b1, 1'b0, 4'h0, 4'h0, 16'h0011);
    issue(4'd0, 16'h0, 16'h0022, 3'd2, 1'b1, 1'b0, 4'h0, 4'h0, 16'h0022);
    chk("bp_in_ready_low", 32'(in_ready), 32'(0));
    drv(4'd0, 16'h0, 16'h0033, 3'd3, 1'b1, 1'b0, 4'h0, 4'h0);
    @(negedge clk);
    chk("bp_stall_ready", 32'(in_ready), 32'(0));
    chk("bp_head_rd",     32'(out_rd),   32'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'd0, 16'h0, 16'h0033, 3'd3, 1'b1, 1'b0, 4'h0, 4'h0, 16'h0033);
    idle(4);

    // Throughput: 8 back-to-back, mixed shifter/ALU opcodes.
    for (int i = 0; i < 8; i++) begin
      drv(t_op[i], 16'hA000 + 16'(i), 16'h5000 + 16'(i), 3'(i), i[0], 1'b0, 4'h0, 4'h0);
      @(negedge clk);
      chk("tp_in_ready", 32'(in_ready), 32'(1));
      if (i > 0) chk("tp_out_valid", 32'(out_valid), 32'(1));
      if (in_ready) sb.push_back('{data: t_exp[i], rd: 3'(i), we: i[0]});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("tp_last_valid", 32'(out_valid), 32'(1));
    @(posedge clk); #1;
    idle(3);

    // Flush with main + skid full.
    out_ready = 1'b0;
    issue(4'd0, 16'h0, 16'h00A4, 3'd4, 1'b1, 1'b1, 4'h0, 4'b0001, 16'h00A4);
    issue(4'd8, 16'h00B5, 16'h0, 3'd5, 1'b0, 1'b0, 4'h0, 4'h0, 16'h00B5);
    chk("fl_cc_before", 32'(cc), 32'(4'b0001));
    drv(4'd0, 16'h0, 16'h0FFF, 3'd6, 1'b1, 1'b1, 4'h0, 4'b0100);
    flush = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'(0));
    chk("fl_in_ready",  32'(in_ready),  32'(1));
    chk("fl_cc_kept",   32'(cc),        32'(4'b0001));
    chk("fl_out_we",    32'(out_we),    32'(0));
    chk("fl_data_hold", 32'(out_data),  32'(16'h00A4));
    chk("fl_rd_hold",   32'(out_rd),    32'(4));
    out_ready = 1'b1;
    idle(3);

    // CC visibility timing.
    drv(4'd10, 16'h0123, 16'h0, 3'd7, 1'b1, 1'b1, 4'b0010, 4'b0000);
    @(negedge clk);
    chk("cc_in_ready", 32'(in_ready), 32'(1));
    if (in_ready) sb.push_back('{data: 16'h0123, rd: 3'd7, we: 1'b1});
`ifdef CC_BYPASS_EN
    chk("cc_same_cycle", 32'(cc), 32'(4'b0010));
`else
    chk("cc_same_cycle", 32'(cc), 32'(4'b0001));
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("cc_next_cycle", 32'(cc), 32'(4'b0010));
    idle(3);

    // Reset mid-operation.
    out_ready = 1'b0;
    issue(4'd0, 16'h0, 16'h0C01, 3'd1, 1'b1, 1'b1, 4'h0, 4'b1111, 16'h0C01);
    issue(4'd0, 16'h0, 16'h0C02, 3'd2, 1'b1, 1'b0, 4'h0, 4'h0, 16'h0C02);
    chk("mr_cc_before", 32'(cc), 32'(4'b1111));
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_out_valid", 32'(out_valid), 32'(0));
    chk("mr_in_ready",  32'(in_ready),  32'(1));
    chk("mr_cc",        32'(cc),        32'(0));
    chk("mr_out_data",  32'(out_data),  32'(0));
    out_ready = 1'b1;
    idle(4);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
